// File: rtl/mmio_responder_pkg.sv
// Shared definitions for the MMIO responder: register offsets, CTRL/STAT bit
// positions and the default window base address.
package mmio_responder_pkg;

  // Word offsets inside the 8-word MMIO window; 5..7 are reserved.
  typedef enum logic [2:0] {
    OffCycle = 3'd0,
    OffCmp   = 3'd1,
    OffCtrl  = 3'd2,
    OffFifo  = 3'd3,
    OffStat  = 3'd4
  } mmio_off_e;

  // CTRL register bits
  localparam int unsigned CtrlTmrEn = 0;
  localparam int unsigned CtrlIrqEn = 1;
  localparam int unsigned CtrlFlag  = 2;

  // STAT register bits ([3:0] hold the FIFO count)
  localparam int unsigned StatFull  = 4;
  localparam int unsigned StatEmpty = 5;
  localparam int unsigned StatOvf   = 6;

  localparam logic [11:0] DefaultBaseAddr = 12'hF00;

endpackage

// File: rtl/mmio_responder_if.sv
// Processor-side dmem signals plus the downstream FIFO valid/ready stream.
interface mmio_responder_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] address_dmem;
  logic [DATA_WIDTH-1:0] data;
  logic                  wren;
  logic [DATA_WIDTH-1:0] q_mmio;
  logic                  mmio_hit;
  logic                  irq;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;

  // Processor + consumer side
  modport master (
    output address_dmem, data, wren, out_ready,
    input  q_mmio, mmio_hit, irq, out_data, out_valid
  );

  // Responder side
  modport slave (
    input  address_dmem, data, wren, out_ready,
    output q_mmio, mmio_hit, irq, out_data, out_valid
  );

endinterface

// File: rtl/mmio_responder_fifo.sv
// Small synchronous FIFO with head exposed combinationally. A push while full
// is accepted only when a pop happens on the same edge.
module mmio_responder_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [CntW-1:0]       o_count,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       r_rd_ptr;
  logic [PtrW-1:0]       r_wr_ptr;
  logic [CntW-1:0]       r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CntW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  // When full, the slot being popped is the one the push overwrites.
  assign w_do_push = i_push & (~w_full | i_pop);
  assign w_do_pop  = i_pop & ~w_empty;

  // Storage, pointers and occupancy count
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder sitting beside dmem: cycle counter, compare timer with sticky
// flag/irq, and an output FIFO. Read data and hit are registered so the top
// level can mux q_mmio over q_dmem with the same one-cycle latency.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 12,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(DefaultBaseAddr),
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input logic              clock,
  input logic              reset,
  mmio_responder_if.slave  bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0] r_cycle;
  logic [DATA_WIDTH-1:0] r_cmp;
  logic [DATA_WIDTH-1:0] r_tmr_cnt;
  logic                  r_tmr_en;
  logic                  r_irq_en;
  logic                  r_flag;
  logic                  r_ovf;
  logic [DATA_WIDTH-1:0] r_q;
  logic                  r_hit;

  logic [DATA_WIDTH-1:0] w_cmp_d;
  logic [DATA_WIDTH-1:0] w_tmr_cnt_d;
  logic                  w_tmr_en_d;
  logic                  w_irq_en_d;
  logic                  w_flag_d;
  logic                  w_ovf_d;
  logic [DATA_WIDTH-1:0] w_q_d;

  logic                  w_hit;
  logic [2:0]            w_off;
  logic                  w_wr;
  logic                  w_wr_cmp;
  logic                  w_wr_ctrl;
  logic                  w_rd_stat;
  logic                  w_tmr_match;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CntW-1:0]       w_count;
  logic [3:0]            w_cnt4;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_ctrl_val;
  logic [DATA_WIDTH-1:0] w_stat_val;

  assign w_hit       = (bus.address_dmem[ADDR_WIDTH-1:3] == BASE_ADDR[ADDR_WIDTH-1:3]);
  assign w_off       = bus.address_dmem[2:0];
  assign w_wr        = bus.wren & w_hit;
  assign w_wr_cmp    = w_wr & (w_off == OffCmp);
  assign w_wr_ctrl   = w_wr & (w_off == OffCtrl);
  // Any access that decodes to STAT counts as a read and clears ovf.
  assign w_rd_stat   = w_hit & (w_off == OffStat);
  assign w_push      = w_wr & (w_off == OffFifo);
  assign w_pop       = ~w_empty & bus.out_ready;
  assign w_tmr_match = r_tmr_en & (r_tmr_cnt == r_cmp);

  assign w_cnt4      = 4'(w_count);
  assign w_ctrl_val  = {{(DATA_WIDTH-3){1'b0}}, r_flag, r_irq_en, r_tmr_en};
  assign w_stat_val  = {{(DATA_WIDTH-7){1'b0}}, r_ovf, w_empty, w_full, w_cnt4};

  mmio_responder_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (bus.data),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Next state for timer, CTRL/CMP and the sticky overflow flag
  always_comb begin
    w_cmp_d     = r_cmp;
    w_tmr_cnt_d = r_tmr_cnt;
    w_tmr_en_d  = r_tmr_en;
    w_irq_en_d  = r_irq_en;
    w_flag_d    = r_flag;
    w_ovf_d     = r_ovf;

    if (r_tmr_en) begin
      w_tmr_cnt_d = w_tmr_match ? '0 : r_tmr_cnt + DATA_WIDTH'(1);
    end
    if (w_wr_cmp) begin
      w_cmp_d     = bus.data;
      w_tmr_cnt_d = '0;
    end
    if (w_wr_ctrl) begin
      w_tmr_en_d = bus.data[CtrlTmrEn];
      w_irq_en_d = bus.data[CtrlIrqEn];
      if (bus.data[CtrlFlag]) begin
        w_flag_d = 1'b0;
      end
    end
    // A match on the same edge as a write-1-clear leaves the flag set.
    if (w_tmr_match) begin
      w_flag_d = 1'b1;
    end

    if (w_rd_stat) begin
      w_ovf_d = 1'b0;
    end
    if (w_push & w_full & ~w_pop) begin
      w_ovf_d = 1'b1;
    end
  end

  // Read mux; reserved offsets and misses return zero
  always_comb begin
    w_q_d = '0;
    if (w_hit) begin
      case (w_off)
        OffCycle: w_q_d = r_cycle;
        OffCmp:   w_q_d = r_cmp;
        OffCtrl:  w_q_d = w_ctrl_val;
        OffStat:  w_q_d = w_stat_val;
        default:  w_q_d = '0;
      endcase
    end
  end

  // State and registered read outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cycle   <= '0;
      r_cmp     <= '0;
      r_tmr_cnt <= '0;
      r_tmr_en  <= 1'b0;
      r_irq_en  <= 1'b0;
      r_flag    <= 1'b0;
      r_ovf     <= 1'b0;
      r_q       <= '0;
      r_hit     <= 1'b0;
    end else begin
      r_cycle   <= r_cycle + DATA_WIDTH'(1);
      r_cmp     <= w_cmp_d;
      r_tmr_cnt <= w_tmr_cnt_d;
      r_tmr_en  <= w_tmr_en_d;
      r_irq_en  <= w_irq_en_d;
      r_flag    <= w_flag_d;
      r_ovf     <= w_ovf_d;
      r_q       <= w_q_d;
      r_hit     <= w_hit;
    end
  end

  assign bus.q_mmio    = r_q;
  assign bus.mmio_hit  = r_hit;
  assign bus.irq       = r_flag & r_irq_en;
  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_head;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, and a randomized traffic phase.
module tb_mmio_responder;

  localparam logic [11:0] Base  = 12'hF00;
  localparam logic [11:0] ACyc  = Base + 12'd0;
  localparam logic [11:0] ACmp  = Base + 12'd1;
  localparam logic [11:0] ACtrl = Base + 12'd2;
  localparam logic [11:0] AFifo = Base + 12'd3;
  localparam logic [11:0] AStat = Base + 12'd4;
  localparam logic [11:0] ARsv  = Base + 12'd6;
  localparam logic [11:0] AIdle = 12'h000;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  mmio_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  mmio_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_cycle, m_cmp, m_tcnt, m_q;
  logic        m_tmr_en, m_irq_en, m_flag, m_ovf, m_hit;
  logic [31:0] m_fifo[$];

  task automatic model_reset();
    m_cycle = 0; m_cmp = 0; m_tcnt = 0; m_q = 0;
    m_tmr_en = 0; m_irq_en = 0; m_flag = 0; m_ovf = 0; m_hit = 0;
    m_fifo.delete();
  endtask

  task automatic model_step();
    logic        hit, push, pop, match, wr;
    logic [2:0]  off;
    logic [31:0] d, rdv;
    int          sz;
    hit = (bus.address_dmem[11:3] == Base[11:3]);
    off = bus.address_dmem[2:0];
    d   = bus.data;
    sz  = m_fifo.size();
    case (off)
      3'd0:    rdv = m_cycle;
      3'd1:    rdv = m_cmp;
      3'd2:    rdv = {29'b0, m_flag, m_irq_en, m_tmr_en};
      3'd4:    rdv = {25'b0, m_ovf, sz == 0, sz == 4, 4'(sz)};
      default: rdv = 0;
    endcase
    wr    = bus.wren && hit;
    push  = wr && off == 3'd3;
    pop   = sz > 0 && bus.out_ready;
    match = m_tmr_en && m_tcnt == m_cmp;
    if (hit && off == 3'd4) m_ovf = 0;
    if (push && sz == 4 && !pop) m_ovf = 1;
    if (pop) void'(m_fifo.pop_front());
    if (push && (sz < 4 || pop)) m_fifo.push_back(d);
    if (m_tmr_en) m_tcnt = match ? 32'd0 : m_tcnt + 32'd1;
    if (wr && off == 3'd1) begin
      m_cmp  = d;
      m_tcnt = 0;
    end
    if (wr && off == 3'd2) begin
      m_tmr_en = d[0];
      m_irq_en = d[1];
      if (d[2]) m_flag = 0;
    end
    if (match) m_flag = 1;
    m_cycle = m_cycle + 32'd1;
    m_q     = hit ? rdv : 32'd0;
    m_hit   = hit;
  endtask

  // Advance model on every edge, then compare shortly after
  always @(posedge clock) begin
    if (!reset) model_reset();
    else model_step();
    #1;
    chk("hit", {31'b0, bus.mmio_hit}, {31'b0, m_hit});
    chk("q_mmio", bus.q_mmio, m_q);
    chk("irq", {31'b0, bus.irq}, {31'b0, m_flag && m_irq_en});
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_fifo.size() != 0});
    if (m_fifo.size() != 0) chk("out_data", bus.out_data, m_fifo[0]);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.address_dmem = a; bus.data = d; bus.wren = 1'b1;
    @(negedge clock);
    bus.wren = 1'b0; bus.address_dmem = AIdle;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v, output logic h);
    @(negedge clock);
    bus.address_dmem = a; bus.wren = 1'b0;
    @(negedge clock);
    v = bus.q_mmio; h = bus.mmio_hit;
    bus.address_dmem = AIdle;
  endtask

  task automatic drain(input logic [31:0] e0, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] exp_l [4];
    exp_l = '{e0, e1, e2, e3};
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      chk("drain order", bus.out_data, exp_l[i]);
      bus.out_ready = 1'b1;
      @(negedge clock);
    end
    chk("drained empty", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] v, v1, v2, cmp0, ctrl0;
    logic        h;

    bus.address_dmem = AIdle; bus.data = '0; bus.wren = 1'b0; bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst q", bus.q_mmio, 32'd0);
    chk("rst hit", {31'b0, bus.mmio_hit}, 32'd0);
    chk("rst irq", {31'b0, bus.irq}, 32'd0);
    chk("rst valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst out_data", bus.out_data, 32'd0);
    reset = 1'b1;

    // CYCLE reads 10 edges apart; miss returns zero
    rd(ACyc, v1, h);
    chk("cycle hit", {31'b0, h}, 32'd1);
    repeat (8) @(negedge clock);
    rd(ACyc, v2, h);
    chk("cycle hit2", {31'b0, h}, 32'd1);
    chk("cycle delta", v2 - v1, 32'd10);
    rd(12'h100, v, h);
    chk("miss hit", {31'b0, h}, 32'd0);
    chk("miss q", v, 32'd0);

    // Timer: CMP=5 fires 6 edges after enable, then every 6
    wr(ACmp, 32'd5);
    wr(ACtrl, 32'h3);
    repeat (5) @(negedge clock);
    chk("irq pre", {31'b0, bus.irq}, 32'd0);
    @(negedge clock);
    chk("irq rise", {31'b0, bus.irq}, 32'd1);
    wr(ACtrl, 32'h7);
    chk("irq cleared", {31'b0, bus.irq}, 32'd0);
    repeat (3) @(negedge clock);
    chk("irq pre2", {31'b0, bus.irq}, 32'd0);
    @(negedge clock);
    chk("irq rise2", {31'b0, bus.irq}, 32'd1);
    rd(ACtrl, v, h);
    chk("ctrl flag", v, 32'h7);
    wr(ACtrl, 32'h4);
    chk("irq off", {31'b0, bus.irq}, 32'd0);

    // FIFO fill, overflow, ordered drain, ovf clear-on-read
    for (int i = 0; i < 4; i++) wr(AFifo, 32'hA + 32'(i));
    rd(AStat, v, h);
    chk("stat full", v, 32'h14);
    wr(AFifo, 32'hE);
    drain(32'hA, 32'hB, 32'hC, 32'hD);
    rd(AStat, v, h);
    chk("stat ovf", v, 32'h60);
    rd(AStat, v, h);
    chk("stat ovf clr", v, 32'h20);

    // Push into full FIFO while popping
    for (int i = 1; i <= 4; i++) wr(AFifo, 32'(i));
    @(negedge clock);
    bus.address_dmem = AFifo; bus.data = 32'hF; bus.wren = 1'b1; bus.out_ready = 1'b1;
    @(negedge clock);
    bus.wren = 1'b0; bus.address_dmem = AIdle; bus.out_ready = 1'b0;
    rd(AStat, v, h);
    chk("stat push+pop", v, 32'h14);
    drain(32'd2, 32'd3, 32'd4, 32'hF);

    // Reserved offset
    rd(ACmp, cmp0, h);
    rd(ACtrl, ctrl0, h);
    chk("cmp kept", cmp0, 32'd5);
    wr(ARsv, 32'hFFFF_FFFF);
    rd(ARsv, v, h);
    chk("rsv q", v, 32'd0);
    chk("rsv hit", {31'b0, h}, 32'd1);
    rd(ACmp, v, h);
    chk("rsv cmp", v, cmp0);
    rd(ACtrl, v, h);
    chk("rsv ctrl", v, ctrl0);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      int off;
      @(negedge clock);
      off = $urandom_range(0, 9);
      if (off > 7) off = 3;
      if ($urandom_range(0, 3) != 0) bus.address_dmem = Base + 12'(off);
      else bus.address_dmem = 12'($urandom_range(0, 4095));
      bus.wren = ($urandom_range(0, 1) == 1);
      case (bus.address_dmem[2:0])
        3'd1:    bus.data = $urandom_range(0, 12);
        3'd2:    bus.data = $urandom_range(0, 7);
        default: bus.data = $urandom;
      endcase
      bus.out_ready = ($urandom_range(0, 9) < ((k < 300) ? 1 : 6));
    end

    // Mid-stream reset with FIFO populated and a read in flight
    @(negedge clock);
    bus.wren = 1'b0; bus.out_ready = 1'b0; bus.address_dmem = AIdle;
    wr(AFifo, 32'h55);
    @(negedge clock);
    bus.address_dmem = ACyc;
    reset = 1'b0;
    #1;
    chk("mid rst q", bus.q_mmio, 32'd0);
    chk("mid rst hit", {31'b0, bus.mmio_hit}, 32'd0);
    chk("mid rst irq", {31'b0, bus.irq}, 32'd0);
    chk("mid rst valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid rst out_data", bus.out_data, 32'd0);
    repeat (3) @(negedge clock);
    bus.address_dmem = AIdle;
    reset = 1'b1;
    rd(AStat, v, h);
    chk("post rst stat", v, 32'h20);
    chk("post rst hit", {31'b0, h}, 32'd1);

    repeat (2) @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
